// File: rtl/cacheline_adaptor.sv
// cacheline_adaptor: bridges a cache-line request port to a burst memory interface,
// splitting writes into beats and assembling read beats into a full line.
module cacheline_adaptor #(
  parameter int CACHE_LINE_WIDTH = 256,
  parameter int BURST_LEN        = 4,
  parameter int BURST_WIDTH      = CACHE_LINE_WIDTH / BURST_LEN,
  parameter int ADDR_WIDTH       = 32
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic [CACHE_LINE_WIDTH-1:0] line_i,
  output logic [CACHE_LINE_WIDTH-1:0] line_o,
  input  logic [ADDR_WIDTH-1:0]       address_i,
  input  logic                        read_i,
  input  logic                        write_i,
  output logic                        resp_o,
  input  logic [BURST_WIDTH-1:0]      burst_i,
  output logic [BURST_WIDTH-1:0]      burst_o,
  output logic [ADDR_WIDTH-1:0]       address_o,
  output logic                        read_o,
  output logic                        write_o,
  input  logic                        resp_i
);
  localparam int CW = BURST_LEN > 1 ? $clog2(BURST_LEN) : 1;
  localparam int OW = $clog2(CACHE_LINE_WIDTH / 8);
  localparam logic [CW-1:0] LAST = CW'(BURST_LEN - 1);
  localparam logic [ADDR_WIDTH-1:0] LINE_MASK = {ADDR_WIDTH{1'b1}} << OW;
  typedef enum logic [1:0] {IDLE, READ, WRITE, DONE} state_e;
  state_e                      state_q;
  logic [CW-1:0]               cnt_q;
  logic [CACHE_LINE_WIDTH-1:0] rline_q, wline_q;
  logic [ADDR_WIDTH-1:0]       addr_q;
  logic                        rd_q, wr_q, resp_q;
  assign line_o    = rline_q;
  assign address_o = addr_q;
  assign read_o    = rd_q;
  assign write_o   = wr_q;
  assign resp_o    = resp_q;
  assign burst_o   = wline_q[BURST_WIDTH*cnt_q +: BURST_WIDTH];
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      rline_q <= '0;
      wline_q <= '0;
      addr_q  <= '0;
      rd_q    <= 1'b0;
      wr_q    <= 1'b0;
      resp_q  <= 1'b0;
    end else begin
      resp_q <= 1'b0;
      case (state_q)
        IDLE: if (read_i || write_i) begin
          state_q <= read_i ? READ : WRITE;
          rd_q    <= read_i;
          wr_q    <= !read_i;
          addr_q  <= address_i & LINE_MASK;
          cnt_q   <= '0;
          if (!read_i) wline_q <= line_i;
        end
        READ, WRITE: if (resp_i) begin
          if (state_q == READ) rline_q[BURST_WIDTH*cnt_q +: BURST_WIDTH] <= burst_i;
          cnt_q <= cnt_q + 1'b1;
          // last beat: drop the memory request and raise the cache completion pulse together
          if (cnt_q == LAST) begin
            state_q <= DONE;
            cnt_q   <= '0;
            rd_q    <= 1'b0;
            wr_q    <= 1'b0;
            resp_q  <= 1'b1;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_cacheline_adaptor.sv
// tb_cacheline_adaptor: scenario tasks driving a cache-side requester and a memory-side
// responder, with line/beat scoreboards filled at stimulus time and drained on DUT output.
module tb_cacheline_adaptor;
  localparam int CLW = 256, BL = 4, BW = 64, AW = 32;
  logic           clk = 1'b0, rst_n = 1'b0;
  logic [CLW-1:0] line_i, line_o;
  logic [AW-1:0]  address_i, address_o;
  logic           read_i, write_i, resp_o, read_o, write_o, resp_i;
  logic [BW-1:0]  burst_i, burst_o;
  int passed = 0, total = 0;
  int resp_cnt = 0, both_cnt = 0, rd_cycles = 0, wr_cycles = 0, low_run = 0, last_gap = 0;
  logic [CLW-1:0] got_lines[$], exp_lines[$];
  logic [BW-1:0]  got_beats[$], exp_beats[$];
  logic [BW-1:0]  beats[BL];
  logic [CLW-1:0] gl;
  logic [BW-1:0]  gb;

  always #5 clk = ~clk;

  cacheline_adaptor dut (
    .clk(clk), .rst_n(rst_n), .line_i(line_i), .line_o(line_o), .address_i(address_i),
    .read_i(read_i), .write_i(write_i), .resp_o(resp_o), .burst_i(burst_i), .burst_o(burst_o),
    .address_o(address_o), .read_o(read_o), .write_o(write_o), .resp_i(resp_i)
  );

  always @(negedge clk) begin
    if (resp_o) begin
      resp_cnt++;
      got_lines.push_back(line_o);
    end
    if (read_o && write_o) both_cnt++;
    if (read_o) rd_cycles++;
    if (write_o) wr_cycles++;
    if (read_o) begin
      if (low_run > 0) last_gap = low_run;
      low_run = 0;
    end else low_run++;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  task automatic req(input logic rd, input logic wr, input logic [AW-1:0] a, input logic [CLW-1:0] l);
    int n = 0;
    read_i = rd; write_i = wr; address_i = a; line_i = l;
    while (!resp_o && n < 100) begin @(negedge clk); n++; end
    read_i = 1'b0; write_i = 1'b0;
    @(negedge clk);
  endtask

  task automatic mem(input int dly, input logic [15:0] pat, input int plen);
    int n = 0, k = 0, b = 0;
    while (!(read_o || write_o) && n < 50) begin @(negedge clk); n++; end
    repeat (dly) @(negedge clk);
    while (b < BL && k < plen) begin
      resp_i  = pat[k];
      burst_i = pat[k] ? beats[b] : 64'hDEAD_BEEF_DEAD_BEEF;
      if (pat[k]) begin
        if (write_o) got_beats.push_back(burst_o);
        b++;
      end
      k++;
      @(negedge clk);
    end
    resp_i = 1'b0; burst_i = '0;
  endtask

  task automatic clear();
    resp_cnt = 0; both_cnt = 0; rd_cycles = 0; wr_cycles = 0;
    got_lines.delete(); exp_lines.delete(); got_beats.delete(); exp_beats.delete();
  endtask

  task automatic test_reset();
    repeat (2) @(negedge clk);
    total++; if ({resp_o, read_o, write_o} !== 3'b000) $display("FAIL rst_ctrl: got %b expected 000", {resp_o, read_o, write_o}); else passed++;
    total++; if (address_o !== '0) $display("FAIL rst_addr: got %h expected 0", address_o); else passed++;
    total++; if (line_o !== '0) $display("FAIL rst_line: got %h expected 0", line_o); else passed++;
    total++; if (burst_o !== '0) $display("FAIL rst_burst: got %h expected 0", burst_o); else passed++;
    rst_n = 1'b1;
  endtask

  task automatic test_read();
    clear();
    beats = '{64'h1111_1111_1111_1111, 64'h2222_2222_2222_2222, 64'h3333_3333_3333_3333, 64'h4444_4444_4444_4444};
    exp_lines.push_back({beats[3], beats[2], beats[1], beats[0]});
    fork
      req(1'b1, 1'b0, 32'h0000_1234, '0);
      mem(5, 16'hF, 4);
    join
    total++; if (address_o !== 32'h0000_1220) $display("FAIL read_addr: got %h expected 00001220", address_o); else passed++;
    total++; if (rd_cycles !== 9) $display("FAIL read_held: got %0d expected 9", rd_cycles); else passed++;
    total++; if (resp_cnt !== 1) $display("FAIL read_resp: got %0d expected 1", resp_cnt); else passed++;
    gl = got_lines.size() ? got_lines[0] : 'x;
    total++; if (gl !== exp_lines[0]) $display("FAIL read_line: got %h expected %h", gl, exp_lines[0]); else passed++;
  endtask

  task automatic test_write();
    logic [BW-1:0] a = 64'hA0A0_A0A0_0000_000A, b = 64'hB0B0_B0B0_0000_000B;
    logic [BW-1:0] c = 64'hC0C0_C0C0_0000_000C, d = 64'hD0D0_D0D0_0000_000D;
    clear();
    exp_beats.push_back(a); exp_beats.push_back(b); exp_beats.push_back(c); exp_beats.push_back(d);
    fork
      req(1'b0, 1'b1, 32'h8000_0040, {d, c, b, a});
      mem(2, 16'hF, 4);
    join
    for (int i = 0; i < BL; i++) begin
      gb = got_beats.size() ? got_beats.pop_front() : 'x;
      total++; if (gb !== exp_beats[i]) $display("FAIL write_beat%0d: got %h expected %h", i, gb, exp_beats[i]); else passed++;
    end
    total++; if (wr_cycles !== 6) $display("FAIL write_held: got %0d expected 6", wr_cycles); else passed++;
    total++; if (rd_cycles !== 0) $display("FAIL write_no_read: got %0d expected 0", rd_cycles); else passed++;
    total++; if (resp_cnt !== 1) $display("FAIL write_resp: got %0d expected 1", resp_cnt); else passed++;
    total++; if (address_o !== 32'h8000_0040) $display("FAIL write_addr: got %h expected 80000040", address_o); else passed++;
  endtask

  task automatic test_gaps();
    clear();
    beats = '{64'h0101_0101_0101_0101, 64'h0202_0202_0202_0202, 64'h0303_0303_0303_0303, 64'h0404_0404_0404_0404};
    exp_lines.push_back({beats[3], beats[2], beats[1], beats[0]});
    fork
      req(1'b1, 1'b0, 32'h0000_0100, '0);
      mem(1, 16'h0059, 7);
    join
    gl = got_lines.size() ? got_lines[0] : 'x;
    total++; if (gl !== exp_lines[0]) $display("FAIL gap_line: got %h expected %h", gl, exp_lines[0]); else passed++;
    total++; if (rd_cycles !== 8) $display("FAIL gap_held: got %0d expected 8", rd_cycles); else passed++;
    total++; if (resp_cnt !== 1) $display("FAIL gap_resp: got %0d expected 1", resp_cnt); else passed++;
  endtask

  task automatic test_simultaneous();
    clear();
    beats = '{64'h5555_0000_0000_0001, 64'h5555_0000_0000_0002, 64'h5555_0000_0000_0003, 64'h5555_0000_0000_0004};
    exp_lines.push_back({beats[3], beats[2], beats[1], beats[0]});
    fork
      req(1'b1, 1'b1, 32'h0000_0040, {4{64'hFFFF_FFFF_FFFF_FFFF}});
      mem(0, 16'hF, 4);
    join
    total++; if (wr_cycles !== 0) $display("FAIL simul_no_write: got %0d expected 0", wr_cycles); else passed++;
    gl = got_lines.size() ? got_lines[0] : 'x;
    total++; if (gl !== exp_lines[0]) $display("FAIL simul_line: got %h expected %h", gl, exp_lines[0]); else passed++;
    total++; if (both_cnt !== 0) $display("FAIL simul_overlap: got %0d expected 0", both_cnt); else passed++;
  endtask

  task automatic test_reset_mid();
    int n = 0;
    clear();
    read_i = 1'b1; address_i = 32'h0000_2000;
    while (!read_o && n < 20) begin @(negedge clk); n++; end
    resp_i = 1'b1; burst_i = 64'hAAAA_AAAA_AAAA_AAAA; @(negedge clk);
    burst_i = 64'hBBBB_BBBB_BBBB_BBBB; @(negedge clk);
    resp_i = 1'b0; read_i = 1'b0; burst_i = '0;
    rst_n = 1'b0;
    #1;
    total++; if ({resp_o, read_o, write_o} !== 3'b000) $display("FAIL mid_rst_ctrl: got %b expected 000", {resp_o, read_o, write_o}); else passed++;
    total++; if (address_o !== '0) $display("FAIL mid_rst_addr: got %h expected 0", address_o); else passed++;
    total++; if (line_o !== '0) $display("FAIL mid_rst_line: got %h expected 0", line_o); else passed++;
    repeat (2) @(negedge clk);
    total++; if (resp_cnt !== 0) $display("FAIL mid_rst_resp: got %0d expected 0", resp_cnt); else passed++;
    rst_n = 1'b1;
    beats = '{64'h0000_0000_0000_0010, 64'h0000_0000_0000_0020, 64'h0000_0000_0000_0030, 64'h0000_0000_0000_0040};
    exp_lines.push_back({beats[3], beats[2], beats[1], beats[0]});
    fork
      req(1'b1, 1'b0, 32'h0000_3004, '0);
      mem(1, 16'hF, 4);
      begin
        @(negedge clk);
        total++; if (read_o !== 1'b1) $display("FAIL first_edge_accept: got %b expected 1", read_o); else passed++;
      end
    join
    gl = got_lines.size() ? got_lines[0] : 'x;
    total++; if (gl !== exp_lines[0]) $display("FAIL post_rst_line: got %h expected %h", gl, exp_lines[0]); else passed++;
    total++; if (address_o !== 32'h0000_3000) $display("FAIL post_rst_addr: got %h expected 00003000", address_o); else passed++;
  endtask

  task automatic test_back_to_back();
    clear();
    beats = '{64'h7000_0000_0000_0001, 64'h7000_0000_0000_0002, 64'h7000_0000_0000_0003, 64'h7000_0000_0000_0004};
    exp_lines.push_back({beats[3], beats[2], beats[1], beats[0]});
    fork
      req(1'b1, 1'b0, 32'h0000_4010, '0);
      mem(3, 16'hF, 4);
    join
    total++; if (address_o !== 32'h0000_4000) $display("FAIL b2b_addr_hold: got %h expected 00004000", address_o); else passed++;
    last_gap = 0;
    beats = '{64'h9000_0000_0000_0001, 64'h9000_0000_0000_0002, 64'h9000_0000_0000_0003, 64'h9000_0000_0000_0004};
    exp_lines.push_back({beats[3], beats[2], beats[1], beats[0]});
    fork
      req(1'b1, 1'b0, 32'h0000_503F, '0);
      mem(0, 16'hF, 4);
    join
    total++; if (last_gap !== 2) $display("FAIL b2b_gap: got %0d expected 2 (done + one idle)", last_gap); else passed++;
    total++; if (address_o !== 32'h0000_5020) $display("FAIL b2b_addr_new: got %h expected 00005020", address_o); else passed++;
    total++; if (resp_cnt !== 2) $display("FAIL b2b_resp: got %0d expected 2", resp_cnt); else passed++;
    for (int i = 0; i < 2; i++) begin
      gl = got_lines.size() ? got_lines.pop_front() : 'x;
      total++; if (gl !== exp_lines[i]) $display("FAIL b2b_line%0d: got %h expected %h", i, gl, exp_lines[i]); else passed++;
    end
  endtask

  initial begin
    read_i = 1'b0; write_i = 1'b0; resp_i = 1'b0;
    address_i = '0; line_i = '0; burst_i = '0;
    test_reset();
    test_read();
    test_write();
    test_gaps();
    test_simultaneous();
    test_reset_mid();
    test_back_to_back();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
